// File: rtl/noc_port_arb.sv
// rtl/noc_port_arb.sv - wormhole round-robin arbiter for one router output port
module noc_port_arb #(
  parameter int N_REQ     = 5,
  parameter int MAX_FLITS = 16,
  parameter int SEL_W     = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(MAX_FLITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_i,
  input  logic             out_ready_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic             beat_o,
  output logic [CNT_W-1:0] flit_cnt_o,
  output logic             err_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W:0]   idx_w;
  logic             win_found;
  logic             last_k;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_limit;

  assign busy_o   = (state == ST_LOCK);
  assign beat_o   = busy_o & (|(gnt_o & req_i)) & out_ready_i;
  assign last_k   = |(gnt_o & last_i);
  assign cnt_inc  = flit_cnt_o + CNT_W'(1);
  assign at_limit = (cnt_inc == CNT_W'(MAX_FLITS));
  assign next_ptr = (sel_o == SEL_W'(N_REQ - 1)) ? '0 : sel_o + SEL_W'(1);

  // Rotating search starting at ptr; the first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_w = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (idx_w >= (SEL_W + 1)'(N_REQ)) begin
        idx_w = idx_w - (SEL_W + 1)'(N_REQ);
      end
      if (!win_found && req_i[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt_o      <= '0;
      sel_o      <= '0;
      flit_cnt_o <= '0;
      err_o      <= 1'b0;
      ptr        <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state      <= ST_LOCK;
            gnt_o      <= {{(N_REQ - 1){1'b0}}, 1'b1} << win_idx;
            sel_o      <= win_idx;
            flit_cnt_o <= '0;
          end
        end
        default: begin
          // Release on tlast, or force release when the packet hits the beat limit.
          if (beat_o) begin
            if (last_k || at_limit) begin
              state      <= ST_IDLE;
              gnt_o      <= '0;
              sel_o      <= '0;
              flit_cnt_o <= '0;
              ptr        <= next_ptr;
              err_o      <= ~last_k;
            end else begin
              flit_cnt_o <= cnt_inc;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_port_arb.sv
// tb/tb_noc_port_arb.sv - directed plus random bench for noc_port_arb with grant scoreboard
module tb_noc_port_arb;
  localparam int N     = 5;
  localparam int MAXF  = 16;
  localparam int SEL_W = 3;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     last;
  logic             rdy;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             beat;
  logic [CNT_W-1:0] cnt;
  logic             err;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  bit sb_en = 1'b1;
  bit busy_q = 1'b0;

  bit m_busy = 1'b0;
  bit m_err  = 1'b0;
  int m_sel  = 0;
  int m_cnt  = 0;
  int m_ptr  = 0;

  noc_port_arb #(.N_REQ(N), .MAX_FLITS(MAXF)) dut (
    .clk(clk), .rst(rst), .req_i(req), .last_i(last), .out_ready_i(rdy),
    .gnt_o(gnt), .sel_o(sel), .busy_o(busy), .beat_o(beat),
    .flit_cnt_o(cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model and scoreboard pop, sampled mid-cycle.
  always @(negedge clk) begin
    logic [15:0] exp_vec;
    logic [15:0] obs_vec;
    logic [N-1:0] exp_gnt;
    bit found;
    int j;
    int w;
    exp_gnt = m_busy ? (N'(1) << m_sel) : '0;
    exp_vec = {m_busy, exp_gnt, (m_busy ? SEL_W'(m_sel) : SEL_W'(0)), CNT_W'(m_cnt), m_err,
               (m_busy && req[m_sel] && rdy)};
    obs_vec = {busy, gnt, sel, cnt, err, beat};
    chk("model", 32'(obs_vec), 32'(exp_vec));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (sb_en && busy && !busy_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(sel), 32'hFFFF);
      end else begin
        w = exp_q.pop_front();
        chk("sb_grant", 32'(sel), 32'(w));
      end
    end
    busy_q = busy;
    if (rst) begin
      m_busy = 0; m_err = 0; m_sel = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_busy) begin
      m_err = 0;
      found = 0;
      for (int i = 0; i < N; i++) begin
        j = (m_ptr + i) % N;
        if (!found && req[j]) begin
          found = 1; m_sel = j;
        end
      end
      if (found) begin
        m_busy = 1; m_cnt = 0;
      end
    end else begin
      m_err = 0;
      if (req[m_sel] && rdy) begin
        if (last[m_sel] || (m_cnt + 1 == MAXF)) begin
          m_err  = !last[m_sel];
          m_busy = 0;
          m_ptr  = (m_sel + 1) % N;
          m_sel  = 0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; last = '0; rdy = 1'b0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // 3-flit packet on input 2
    req = 5'b00100; rdy = 1'b1; exp_q.push_back(2);
    tick();
    chk("t1_gnt", 32'(gnt), 32'b00100);
    chk("t1_sel", 32'(sel), 32'd2);
    chk("t1_beat1", 32'(beat), 32'd1);
    tick();
    chk("t1_cnt1", 32'(cnt), 32'd1);
    tick();
    chk("t1_cnt2", 32'(cnt), 32'd2);
    last = 5'b00100;
    chk("t1_beat3", 32'(beat), 32'd1);
    tick();
    chk("t1_release", 32'(gnt), 32'd0);
    // ptr is now 3: from 3 the search reaches 0 before 2
    req = 5'b00101; last = 5'b00101; exp_q.push_back(0);
    tick();
    chk("t1_ptr3", 32'(sel), 32'd0);
    tick();
    req = '0;
    tick();

    // All inputs requesting, single-flit packets
    rst = 1'b1; tick(); rst = 1'b0;
    req = 5'b11111; last = 5'b11111;
    for (int i = 0; i < 6; i++) exp_q.push_back(i % N);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_gnt", 32'(gnt), 32'(1 << (i % N)));
      tick();
      chk("t2_gap", 32'(gnt), 32'd0);
    end
    req = '0; last = '0;
    tick();

    // Stall on input 1 while input 3 requests
    req = 5'b00010; exp_q.push_back(1);
    tick();
    tick();
    rdy = 1'b0; req = 5'b01010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_gnt", 32'(gnt), 32'b00010);
      chk("t3_hold_cnt", 32'(cnt), 32'd1);
    end
    rdy = 1'b1;
    tick();
    tick();
    chk("t3_cnt3", 32'(cnt), 32'd3);
    last = 5'b00010;
    tick();
    chk("t3_release", 32'(gnt), 32'd0);
    last = 5'b01000; exp_q.push_back(3);
    tick();
    chk("t3_switch", 32'(gnt), 32'b01000);
    tick();
    req = '0; last = '0;
    tick();

    // Watchdog on input 0 (never asserts last)
    req = 5'b00001; exp_q.push_back(0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t4_cnt15", 32'(cnt), 32'd15);
    chk("t4_err_pre", 32'(err), 32'd0);
    tick();
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_force_rel", 32'(busy), 32'd0);
    req = '0;
    tick();
    chk("t4_err_pulse", 32'(err), 32'd0);
    // ptr is now 1; a 16-beat packet with last on beat 16 is a clean release
    req = 5'b00011; exp_q.push_back(1);
    tick();
    chk("t4_ptr1", 32'(sel), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    last = 5'b00010;
    tick();
    chk("t4_norm_rel", 32'(busy), 32'd0);
    chk("t4_no_err", 32'(err), 32'd0);
    req = '0; last = '0;
    tick();

    // Reset while locked on input 4
    req = 5'b10000; exp_q.push_back(4);
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("t5_cnt5", 32'(cnt), 32'd5);
    rst = 1'b1;
    tick();
    chk("t5_rst", 32'({gnt, sel, busy, cnt, err}), 32'd0);
    rst = 1'b0; req = 5'b10001; last = 5'b10001; exp_q.push_back(0);
    tick();
    chk("t5_ptr0", 32'(gnt), 32'b00001);
    tick();
    req = '0; last = '0;
    tick();

    // Random traffic checked by the reference model
    sb_en = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      req  = N'($urandom);
      last = N'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      tick();
    end
    req = '0; rdy = 1'b0;
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
